// File: rtl/tt_um_serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// the bit-counter width helper.
package tt_um_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } arith_state_e;

  // A 1-bit counter is still needed when the operand is narrow.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full subtractor: d = a - b - bin, with bout set on underflow.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial subtractor: A - B - Bin, LSB first, one bit per clock through a
// single full-subtractor cell, with the result published on RUN->DONE.
module tt_um_serial_subtractor
  import tt_um_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
);

  localparam int CW = cnt_width(WIDTH);

  arith_state_e     state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic             cell_d, cell_bout;

  fullsubtractor u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (brw_q),
    .d   (cell_d),
    .bout(cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          brw_d   = Bin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = cell_bout;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        // Last bit: the freshly shifted result is what gets published.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign Diff = diff_q;
  assign Bout = bout_q;

endmodule
